// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared widths, access size codes and controller state encoding
package dmem_ctrl_pkg;
  localparam int RegBus = 32;
  localparam int RegAddrBus = 5;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  typedef enum logic [1:0] {DM_IDLE, DM_REQ, DM_WAIT, DM_DONE} dm_state_t;
endpackage

// File: rtl/dmem_ctrl_lane.sv
// mem_lane: store lane replication and load byte/half extraction with extension
module mem_lane
  import dmem_ctrl_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [1:0]        off,
  input  logic [RegBus-1:0] wdata,
  input  logic [RegBus-1:0] rdata,
  output logic [RegBus-1:0] wrep,
  output logic [RegBus-1:0] rext
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    wrep = size == SIZE_B ? {4{wdata[7:0]}} : size == SIZE_H ? {2{wdata[15:0]}} : wdata;
    rext = size == SIZE_B ? {{24{sign & b[7]}}, b} : size == SIZE_H ? {{16{sign & h[15]}}, h} : rdata;
  end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: sequences one load/store per MEM-stage instruction over the req/addr_ok/data_ok bus
module dmem_ctrl
  import dmem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic              mem_wr,
  input  logic [1:0]        mem_size,
  input  logic              mem_sign,
  input  logic [RegBus-1:0] mem_addr,
  input  logic [RegBus-1:0] mem_wdata,
  input  logic              flush,
  output logic              mem_stall,
  output logic [RegBus-1:0] memdata,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [RegBus-1:0] data_addr,
  output logic [RegBus-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [RegBus-1:0] data_rdata
);
  dm_state_t state;
  logic cancel, sign_q;
  logic [1:0] off_q, lane_size;
  logic [RegBus-1:0] wrep, rext;
  assign lane_size = state == DM_IDLE ? mem_size : data_size;
  assign mem_stall = mem_en & (state != DM_DONE) & ~rst;
  mem_lane u_lane (
    .size (lane_size),
    .sign (sign_q),
    .off  (off_q),
    .wdata(mem_wdata),
    .rdata(data_rdata),
    .wrep (wrep),
    .rext (rext)
  );
  // a flushed access still finishes on the bus, then drops straight back to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DM_IDLE;
      cancel <= 1'b0;
      memdata <= '0;
      data_req <= 1'b0;
      data_wr <= 1'b0;
      data_size <= 2'd0;
      data_addr <= '0;
      data_wdata <= '0;
      sign_q <= 1'b0;
      off_q <= 2'd0;
    end else begin
      case (state)
        DM_IDLE: if (mem_en & ~flush) begin
          state <= DM_REQ;
          cancel <= 1'b0;
          data_req <= 1'b1;
          data_wr <= mem_wr;
          data_size <= mem_size;
          data_addr <= mem_addr;
          data_wdata <= wrep;
          sign_q <= mem_sign;
          off_q <= mem_addr[1:0];
        end
        DM_REQ: begin
          cancel <= cancel | flush;
          if (data_addr_ok) begin
            data_req <= 1'b0;
            state <= DM_WAIT;
          end
        end
        DM_WAIT: if (data_data_ok) begin
          state <= (cancel | flush) ? DM_IDLE : DM_DONE;
          cancel <= 1'b0;
          if (~cancel & ~flush & ~data_wr) memdata <= rext;
        end else cancel <= cancel | flush;
        DM_DONE: state <= DM_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed and random accesses against a bus responder and an arithmetic lane model
module tb_dmem_ctrl;
  logic clk = 0, rst = 1;
  logic mem_en = 0, mem_wr = 0, mem_sign = 0, flush = 0;
  logic [1:0] mem_size = 0;
  logic [31:0] mem_addr = 0, mem_wdata = 0;
  logic mem_stall, data_req, data_wr;
  logic [1:0] data_size;
  logic [31:0] memdata, data_addr, data_wdata;
  logic data_addr_ok = 0, data_data_ok = 0;
  logic [31:0] data_rdata = 0;
  int tests = 0, fails = 0;
  logic [31:0] exp_mem = 0;

  always #5 clk = ~clk;

  dmem_ctrl dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_sign(mem_sign), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .flush(flush),
    .mem_stall(mem_stall), .memdata(memdata), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int width(input logic [1:0] sz);
    return sz == 0 ? 8 : sz == 1 ? 16 : 32;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] r, input logic [1:0] sz, input logic sg, input logic [1:0] off);
    int w = width(sz);
    int sh = sz == 0 ? int'(off) * 8 : sz == 1 ? int'(off[1]) * 16 : 0;
    logic [63:0] m = (64'd1 << w) - 64'd1;
    logic [63:0] v = ({32'd0, r} >> sh) & m;
    if (sg && v[w-1]) v = v | ~m;
    return v[31:0];
  endfunction

  function automatic logic [31:0] rep(input logic [31:0] wd, input logic [1:0] sz);
    int w = width(sz);
    logic [63:0] v = {32'd0, wd} & ((64'd1 << w) - 64'd1);
    logic [63:0] r = 0;
    for (int k = 0; k < 32 / w; k++) r = r | (v << (k * w));
    return r[31:0];
  endfunction

  // ad: extra cycles req waits for addr_ok; dd: cycles from accept to data_ok; fl: flush cycle or -1
  task automatic access(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ad, input int dd, input int fl);
    int reqc = 0, acc = -1;
    bit cx = 0, done = 0;
    int fin = 2 + ad + dd;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      mem_en = 1; mem_wr = wr; mem_size = sz; mem_sign = sg; mem_addr = a; mem_wdata = wd;
      flush = (c == fl); data_addr_ok = 0; data_data_ok = 0; data_rdata = $urandom;
      if (c == fl) cx = 1;
      #1;
      chk("req", {31'd0, data_req}, {31'd0, c >= 1 && acc < 0});
      if (data_req) begin
        chk("addr", data_addr, a);
        chk("wr", {31'd0, data_wr}, {31'd0, wr});
        chk("size", {30'd0, data_size}, {30'd0, sz});
        chk("wdata", data_wdata, rep(wd, sz));
        if (reqc == ad) begin data_addr_ok = 1; acc = c; end
        reqc++;
      end else if (acc >= 0 && c == acc + dd) begin
        data_data_ok = 1; data_rdata = rd;
        if (cx) done = 1;
      end
      #1;
      chk("stall", {31'd0, mem_stall}, {31'd0, cx || c < fin});
      if (!cx && c == fin) begin
        if (!wr) exp_mem = ext(rd, sz, sg, a[1:0]);
        chk("memdata", memdata, exp_mem);
        done = 1;
      end
    end
    chk("timeout", {31'd0, done}, 32'd1);
    @(negedge clk);
    mem_en = 0; flush = 0; data_addr_ok = 0; data_data_ok = 0;
    #1;
    chk("idle_stall", {31'd0, mem_stall}, 32'd0);
    chk("idle_req", {31'd0, data_req}, 32'd0);
    chk("idle_memdata", memdata, exp_mem);
  endtask

  initial begin
    @(negedge clk); mem_en = 1;
    @(negedge clk); #1;
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_memdata", memdata, 32'd0);
    chk("rst_req", {31'd0, data_req}, 32'd0);
    chk("rst_wr", {31'd0, data_wr}, 32'd0);
    chk("rst_size", {30'd0, data_size}, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    chk("rst_wdata", data_wdata, 32'd0);
    mem_en = 0; rst = 0;
    access(0, 2, 0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, -1);
    chk("word_load", memdata, 32'hDEADBEEF);
    access(0, 0, 1, 32'h103, 32'h0, 32'h80112233, 0, 1, -1);
    chk("sbyte_load", memdata, 32'hFFFFFF80);
    access(0, 1, 0, 32'h102, 32'h0, 32'h80112233, 0, 1, -1);
    chk("uhalf_load", memdata, 32'h00008011);
    access(1, 1, 0, 32'h2, 32'h0000ABCD, 32'h55555555, 0, 1, -1);
    chk("half_store_keep", memdata, 32'h00008011);
    access(0, 2, 0, 32'h200, 32'h0, 32'hCAFEF00D, 3, 2, -1);
    access(0, 2, 0, 32'h300, 32'h0, 32'h11111111, 0, 2, 2);
    access(0, 0, 0, 32'h301, 32'h0, 32'h0000A500, 0, 1, -1);
    chk("after_flush_load", memdata, 32'h000000A5);
    access(0, 2, 0, 32'h304, 32'h0, 32'h22222222, 1, 1, 2);
    access(0, 2, 0, 32'h308, 32'h0, 32'h33333333, 0, 1, 2);
    access(0, 2, 0, 32'h30C, 32'h0, 32'h44444444, 0, 1, 1);
    chk("flush_keep", memdata, 32'h000000A5);
    access(0, 3, 1, 32'h400, 32'h0, 32'h87654321, 0, 1, -1);
    chk("size3_load", memdata, 32'h87654321);
    for (int i = 0; i < 24; i++) begin
      logic [1:0] sz = 2'($urandom_range(0, 3));
      logic [31:0] a = $urandom;
      int ad = $urandom_range(0, 2), dd = $urandom_range(1, 3);
      if (sz == 1) a[0] = 0;
      if (sz >= 2) a[1:0] = 0;
      access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom, ad, dd,
             $urandom_range(0, 4) == 0 ? $urandom_range(1, 1 + ad + dd) : -1);
    end
    access(0, 2, 0, 32'h500, 32'h0, 32'h12345678, 0, 1, -1);
    @(negedge clk);
    mem_en = 1; mem_wr = 0; mem_size = 2; mem_addr = 32'h600;
    @(negedge clk); data_addr_ok = 1;
    @(negedge clk); data_addr_ok = 0; rst = 1; #1;
    chk("rst_wait_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk); #1;
    chk("rst_wait_req", {31'd0, data_req}, 32'd0);
    chk("rst_wait_memdata", memdata, 32'd0);
    chk("rst_wait_stall2", {31'd0, mem_stall}, 32'd0);
    rst = 0; #1;
    chk("post_rst_idle_stall", {31'd0, mem_stall}, 32'd1);
    mem_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
